// File: rtl/clk_tick_gen.sv
// Multi-channel power-of-two rate generator: per-channel 50% square wave plus a
// one-cycle tick, with global run/pause and single-step. Optional CLK_TICK_GEN_INPUT_SYNC_EN.
module clk_tick_gen #(
  parameter int unsigned SYS_CLK_SPEED = 100_000_000,
  parameter int unsigned NUM_CH        = 2,
  parameter int unsigned SEL_W         = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH*SEL_W-1:0]   clk_speed,
  input  logic                      run_en,
  input  logic                      step,
  output logic [NUM_CH-1:0]         s_clk,
  output logic [NUM_CH-1:0]         tick
);

  localparam int unsigned CW = $clog2(SYS_CLK_SPEED);

  logic [NUM_CH*SEL_W-1:0] spd_in;
  logic                    run_in;
  logic                    step_in;

`ifdef CLK_TICK_GEN_INPUT_SYNC_EN
  logic [NUM_CH*SEL_W-1:0] spd_s1, spd_s2;
  logic                    run_s1, run_s2;
  logic                    step_s1, step_s2;

  // Two-flop synchronisers for inputs from a foreign clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_s1  <= '0;
      spd_s2  <= '0;
      run_s1  <= 1'b0;
      run_s2  <= 1'b0;
      step_s1 <= 1'b0;
      step_s2 <= 1'b0;
    end else begin
      spd_s1  <= clk_speed;
      spd_s2  <= spd_s1;
      run_s1  <= run_en;
      run_s2  <= run_s1;
      step_s1 <= step;
      step_s2 <= step_s1;
    end
  end

  assign spd_in  = spd_s2;
  assign run_in  = run_s2;
  assign step_in = step_s2;
`else
  assign spd_in  = clk_speed;
  assign run_in  = run_en;
  assign step_in = step;
`endif

  logic [NUM_CH*SEL_W-1:0] spd_q;
  logic                    step_d;
  logic                    step_edge;
  logic [CW-1:0]           cnt [NUM_CH];

  assign step_edge = step_in & ~step_d;

  // Terminal count (HALF-1) for a select; very fast rates clamp HALF to 1
  function automatic logic [CW-1:0] half_m1(input logic [SEL_W-1:0] sel);
    int unsigned h;
    h = SYS_CLK_SPEED >> (32'(sel) + 32'd1);
    if (h == 0) h = 1;
    return CW'(h - 32'd1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_q  <= '0;
      step_d <= 1'b0;
      s_clk  <= '0;
      tick   <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      spd_q  <= spd_in;
      step_d <= step_in;
      for (int i = 0; i < NUM_CH; i++) begin
        // Priority: rate change, then free-run, then single-step while paused
        if (spd_in[i*SEL_W +: SEL_W] != spd_q[i*SEL_W +: SEL_W]) begin
          cnt[i]   <= '0;
          s_clk[i] <= 1'b0;
          tick[i]  <= 1'b0;
        end else if (run_in) begin
          if (cnt[i] == half_m1(spd_q[i*SEL_W +: SEL_W])) begin
            cnt[i]   <= '0;
            s_clk[i] <= ~s_clk[i];
            tick[i]  <= ~s_clk[i];
          end else begin
            cnt[i]   <= cnt[i] + CW'(1);
            tick[i]  <= 1'b0;
          end
        end else if (step_edge) begin
          cnt[i]   <= '0;
          s_clk[i] <= ~s_clk[i];
          tick[i]  <= ~s_clk[i];
        end else begin
          tick[i]  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// Directed bench for clk_tick_gen at SYS_CLK_SPEED=1000, two channels.
module tb_clk_tick_gen;

`ifdef CLK_TICK_GEN_INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] clk_speed;
  logic       run_en;
  logic       step;
  logic [1:0] s_clk;
  logic [1:0] tick;

  int ec;
  int n_vec = 0;
  int n_miss = 0;

  clk_tick_gen #(
    .SYS_CLK_SPEED(1000),
    .NUM_CH       (2),
    .SEL_W        (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_speed(clk_speed),
    .run_en   (run_en),
    .step     (step),
    .s_clk    (s_clk),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at edge %0d", ec);
    $fatal(1, "watchdog");
  end

  // Advance to post-reset edge e; sample point is 1 time unit after that edge
  task automatic adv(input int e);
    while (ec < e) begin
      @(posedge clk);
      #1;
      ec++;
    end
  endtask

  task automatic do_reset(input logic [5:0] spd);
    rst_n     = 1'b0;
    clk_speed = spd;
    run_en    = 1'b1;
    step      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ec    = 0;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    clk_speed = {3'd3, 3'd0};
    run_en    = 1'b1;
    step      = 1'b0;
    #2;
    if (s_clk !== 2'b00 || tick !== 2'b00) begin
      $display("FAIL reset_async s_clk=%b tick=%b expected 00 00", s_clk, tick);
      n_miss++;
    end
    n_vec++;
    repeat (3) @(posedge clk);
    #1;
    if (s_clk !== 2'b00 || tick !== 2'b00) begin
      $display("FAIL reset_held s_clk=%b tick=%b expected 00 00", s_clk, tick);
      n_miss++;
    end
    n_vec++;
  endtask

  // ch0 sel=0 (HALF 500), ch1 sel=3 (HALF 62, restarts on edge 1)
  task automatic test_run;
    int         ev [9] = '{62, 63, 125, 187, 499, 500, 501, 1000, 1457};
    logic [1:0] sv [9] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
    logic [1:0] tv [9] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    do_reset({3'd3, 3'd0});
    for (int k = 0; k < 9; k++) begin
      adv(ev[k] + LAT);
      if (s_clk !== sv[k] || tick !== tv[k]) begin
        $display("FAIL run e=%0d s_clk=%b tick=%b expected %b %b", ev[k], s_clk, tick, sv[k], tv[k]);
        n_miss++;
      end
      n_vec++;
    end
  endtask

  // ch1 changes 3->1 when its counter is 30 (s_clk high); new HALF 250
  task automatic test_rate_change;
    int         ev [6] = '{1458, 1500, 1707, 1708, 1958, 2000};
    logic [1:0] sv [6] = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b01, 2'b00};
    logic [1:0] tv [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
    adv(1457);
    clk_speed = {3'd1, 3'd0};
    for (int k = 0; k < 6; k++) begin
      adv(ev[k] + LAT);
      if (s_clk !== sv[k] || tick !== tv[k]) begin
        $display("FAIL rate_change e=%0d s_clk=%b tick=%b expected %b %b", ev[k], s_clk, tick, sv[k], tv[k]);
        n_miss++;
      end
      n_vec++;
    end
  endtask

  // Pause at ch0 count 200 for 300 cycles; ch0 toggle moves from 2500 to 2800
  task automatic test_pause;
    int         nt = 0;
    int         ev [3] = '{2508, 2799, 2800};
    logic [1:0] sv [3] = '{2'b10, 2'b00, 2'b01};
    logic [1:0] tv [3] = '{2'b10, 2'b00, 2'b01};
    adv(2200);
    run_en = 1'b0;
    for (int e = 2201; e <= 2500 + LAT; e++) begin
      adv(e);
      if (e == 2500) run_en = 1'b1;
      if (e > 2200 + LAT && tick != 2'b00) nt++;
    end
    if (s_clk !== 2'b00 || nt !== 0) begin
      $display("FAIL pause_frozen s_clk=%b ticks=%0d expected 00 0", s_clk, nt);
      n_miss++;
    end
    n_vec++;
    for (int k = 0; k < 3; k++) begin
      adv(ev[k] + LAT);
      if (s_clk !== sv[k] || tick !== tv[k]) begin
        $display("FAIL resume e=%0d s_clk=%b tick=%b expected %b %b", ev[k], s_clk, tick, sv[k], tv[k]);
        n_miss++;
      end
      n_vec++;
    end
  endtask

  // Restart both channels while pausing, then single-step
  task automatic test_step;
    logic [1:0] sv [4] = '{2'b11, 2'b00, 2'b11, 2'b00};
    adv(2900);
    clk_speed = {3'd2, 3'd1};
    run_en    = 1'b0;
    adv(2901 + LAT);
    if (s_clk !== 2'b00 || tick !== 2'b00) begin
      $display("FAIL step_setup s_clk=%b tick=%b expected 00 00", s_clk, tick);
      n_miss++;
    end
    n_vec++;
    for (int k = 0; k < 4; k++) begin
      adv(2910 + 4 * k);
      step = 1'b1;
      adv(2911 + 4 * k);
      step = 1'b0;
      adv(2911 + 4 * k + LAT);
      if (s_clk !== sv[k] || tick !== sv[k]) begin
        $display("FAIL step%0d s_clk=%b tick=%b expected %b %b", k + 1, s_clk, tick, sv[k], sv[k]);
        n_miss++;
      end
      n_vec++;
      adv(2912 + 4 * k + LAT);
      if (s_clk !== sv[k] || tick !== 2'b00) begin
        $display("FAIL step%0d_after s_clk=%b tick=%b expected %b 00", k + 1, s_clk, tick, sv[k]);
        n_miss++;
      end
      n_vec++;
    end
    adv(2930);
    step = 1'b1;
    adv(2931 + LAT);
    if (s_clk !== 2'b11 || tick !== 2'b11) begin
      $display("FAIL step_hold_edge s_clk=%b tick=%b expected 11 11", s_clk, tick);
      n_miss++;
    end
    n_vec++;
    adv(2940);
    step = 1'b0;
    adv(2945 + LAT);
    if (s_clk !== 2'b11 || tick !== 2'b00) begin
      $display("FAIL step_hold_once s_clk=%b tick=%b expected 11 00", s_clk, tick);
      n_miss++;
    end
    n_vec++;
  endtask

  // Step edges while running are ignored; async reset clears a live tick
  task automatic test_step_running;
    do_reset({3'd3, 3'd0});
    for (int k = 0; k < 4; k++) begin
      adv(10 + 10 * k);
      step = 1'b1;
      adv(11 + 10 * k);
      step = 1'b0;
    end
    adv(62 + LAT);
    if (s_clk !== 2'b00) begin
      $display("FAIL run_step_ignored s_clk=%b expected 00", s_clk);
      n_miss++;
    end
    n_vec++;
    adv(63 + LAT);
    if (s_clk !== 2'b10 || tick !== 2'b10) begin
      $display("FAIL run_step_timing s_clk=%b tick=%b expected 10 10", s_clk, tick);
      n_miss++;
    end
    n_vec++;
    #2;
    rst_n = 1'b0;
    #1;
    if (s_clk !== 2'b00 || tick !== 2'b00) begin
      $display("FAIL async_reset s_clk=%b tick=%b expected 00 00", s_clk, tick);
      n_miss++;
    end
    n_vec++;
    #20;
    rst_n = 1'b1;
  endtask

  // sel=7: HALF 3, rises on edges 4 and 10, falls on 7
  task automatic test_fast;
    logic [1:0] sv [8] = '{2'b00, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11};
    logic [1:0] tv [8] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11};
    do_reset({3'd7, 3'd7});
    for (int k = 0; k < 8; k++) begin
      adv(3 + k + LAT);
      if (s_clk !== sv[k] || tick !== tv[k]) begin
        $display("FAIL fast e=%0d s_clk=%b tick=%b expected %b %b", 3 + k, s_clk, tick, sv[k], tv[k]);
        n_miss++;
      end
      n_vec++;
    end
  endtask

  initial begin
    ec = 0;
    test_reset;
    test_run;
    test_rate_change;
    test_pause;
    test_step;
    test_step_running;
    test_fast;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
